// File: rtl/panic_desc_gen.sv
// Builds one packet descriptor per RX packet: fields are taken from the parser on the first beat,
// the byte length is counted from tkeep, and the result is queued for the scheduler.
`ifndef PANIC_DESC_PRIO_SIZE
`define PANIC_DESC_PRIO_SIZE 8
`endif
`ifndef PANIC_DESC_CHAIN_SIZE
`define PANIC_DESC_CHAIN_SIZE 8
`endif
`ifndef PANIC_DESC_TIME_SIZE
`define PANIC_DESC_TIME_SIZE 16
`endif
`ifndef PANIC_DESC_LEN_SIZE
`define PANIC_DESC_LEN_SIZE 16
`endif
`ifndef PANIC_DESC_FLOW_SIZE
`define PANIC_DESC_FLOW_SIZE 16
`endif

module panic_desc_gen #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [KEEP_WIDTH-1:0]             s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic [`PANIC_DESC_PRIO_SIZE-1:0]  s_desc_prio,
  input  logic [`PANIC_DESC_CHAIN_SIZE-1:0] s_desc_chain,
  input  logic [`PANIC_DESC_TIME_SIZE-1:0]  s_desc_time,
  input  logic [`PANIC_DESC_LEN_SIZE-1:0]   s_desc_pk_len,
  input  logic [`PANIC_DESC_FLOW_SIZE-1:0]  s_desc_flow_id,
  output logic [`PANIC_DESC_PRIO_SIZE-1:0]  m_desc_prio,
  output logic [`PANIC_DESC_CHAIN_SIZE-1:0] m_desc_chain,
  output logic [`PANIC_DESC_TIME_SIZE-1:0]  m_desc_time,
  output logic [`PANIC_DESC_LEN_SIZE-1:0]   m_desc_pk_len,
  output logic [`PANIC_DESC_FLOW_SIZE-1:0]  m_desc_flow_id,
  output logic                              m_desc_valid,
  input  logic                              m_desc_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       mismatch_count,
  output logic                              dbg_state
);
  localparam int LW = `PANIC_DESC_LEN_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [`PANIC_DESC_PRIO_SIZE-1:0]  prio;
    logic [`PANIC_DESC_CHAIN_SIZE-1:0] chain;
    logic [`PANIC_DESC_TIME_SIZE-1:0]  time_v;
    logic [`PANIC_DESC_FLOW_SIZE-1:0]  flow_id;
    logic [LW-1:0]                     pk_len;
  } desc_t;

  typedef enum logic {ST_SOP = 1'b0, ST_MID = 1'b1} state_t;

  // Handshake: the tapped stream moves one beat when tvalid && tready; the descriptor
  // port transfers its head when m_desc_valid && m_desc_ready.
  state_t state, state_nxt;
  logic   beat, sop_beat, commit;

  desc_t         cap;
  logic [LW-1:0] byte_cnt;
  logic [LW-1:0] keep_cnt;
  logic [LW:0]   sum;
  logic [LW-1:0] cur_len;
  desc_t         entry;
  logic [LW-1:0] ref_len;

  desc_t         mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, push_ok, drop;
  desc_t         head;

  assign beat = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (beat) state_nxt = s_axis_tlast ? ST_SOP : ST_MID;
  end

  always_comb begin
    sop_beat = beat && (state == ST_SOP);
    commit   = beat && s_axis_tlast;
  end

  assign dbg_state = (state == ST_MID);

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) keep_cnt = keep_cnt + LW'(s_axis_tkeep[i]);
  end

  // Length saturates rather than wraps so oversize packets still register as mismatches.
  always_comb begin
    sum     = {1'b0, byte_cnt} + {1'b0, keep_cnt};
    cur_len = sop_beat ? keep_cnt : (sum[LW] ? '1 : sum[LW-1:0]);
    if (sop_beat) begin
      entry.prio    = s_desc_prio;
      entry.chain   = s_desc_chain;
      entry.time_v  = s_desc_time;
      entry.flow_id = s_desc_flow_id;
      ref_len       = s_desc_pk_len;
    end else begin
      entry.prio    = cap.prio;
      entry.chain   = cap.chain;
      entry.time_v  = cap.time_v;
      entry.flow_id = cap.flow_id;
      ref_len       = cap.pk_len;
    end
    entry.pk_len = cur_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap      <= '0;
      byte_cnt <= '0;
    end else begin
      if (sop_beat) begin
        cap.prio    <= s_desc_prio;
        cap.chain   <= s_desc_chain;
        cap.time_v  <= s_desc_time;
        cap.flow_id <= s_desc_flow_id;
        cap.pk_len  <= s_desc_pk_len;
      end
      if (beat) byte_cnt <= cur_len;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_desc_ready;
  assign push_ok = commit && (!full || pop);
  assign drop    = commit && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      drop_count     <= '0;
      mismatch_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (commit && (cur_len != ref_len) && mismatch_count != 16'hFFFF)
        mismatch_count <= mismatch_count + 16'd1;
    end
  end

  // Fields read as zero while empty so stale FIFO contents never leak out.
  assign head           = mem[rd_ptr[AW-1:0]];
  assign m_desc_valid   = !empty;
  assign fifo_level     = wr_ptr - rd_ptr;
  assign m_desc_prio    = m_desc_valid ? head.prio    : '0;
  assign m_desc_chain   = m_desc_valid ? head.chain   : '0;
  assign m_desc_time    = m_desc_valid ? head.time_v  : '0;
  assign m_desc_flow_id = m_desc_valid ? head.flow_id : '0;
  assign m_desc_pk_len  = m_desc_valid ? head.pk_len  : '0;

endmodule

// File: tb/tb_panic_desc_gen.sv
// Directed bench for panic_desc_gen: a queue-based descriptor model checked every cycle,
// plus literal checks at the points the test plan calls out.
`ifndef PANIC_DESC_PRIO_SIZE
`define PANIC_DESC_PRIO_SIZE 8
`endif
`ifndef PANIC_DESC_CHAIN_SIZE
`define PANIC_DESC_CHAIN_SIZE 8
`endif
`ifndef PANIC_DESC_TIME_SIZE
`define PANIC_DESC_TIME_SIZE 16
`endif
`ifndef PANIC_DESC_LEN_SIZE
`define PANIC_DESC_LEN_SIZE 16
`endif
`ifndef PANIC_DESC_FLOW_SIZE
`define PANIC_DESC_FLOW_SIZE 16
`endif

module tb_panic_desc_gen;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int DEPTH = 8;

  logic          clk = 0;
  logic          rst = 1;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 0, s_axis_tready = 0, s_axis_tlast = 0;
  logic [7:0]    s_desc_prio = '0, s_desc_chain = '0;
  logic [15:0]   s_desc_time = '0, s_desc_pk_len = '0, s_desc_flow_id = '0;
  logic [7:0]    m_desc_prio, m_desc_chain;
  logic [15:0]   m_desc_time, m_desc_pk_len, m_desc_flow_id;
  logic          m_desc_valid;
  logic          m_desc_ready = 0;
  logic [3:0]    fifo_level;
  logic [15:0]   drop_count, mismatch_count;
  logic          dbg_state;

  panic_desc_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_desc_prio(s_desc_prio), .s_desc_chain(s_desc_chain), .s_desc_time(s_desc_time),
    .s_desc_pk_len(s_desc_pk_len), .s_desc_flow_id(s_desc_flow_id),
    .m_desc_prio(m_desc_prio), .m_desc_chain(m_desc_chain), .m_desc_time(m_desc_time),
    .m_desc_pk_len(m_desc_pk_len), .m_desc_flow_id(m_desc_flow_id),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .fifo_level(fifo_level), .drop_count(drop_count), .mismatch_count(mismatch_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected FIFO contents packed as {prio, chain, time, flow, len}.
  logic [63:0] exp_q[$];
  bit          started = 0;
  bit          in_pkt;
  int          m_cnt, m_drop, m_mism, m_sz, m_n;
  bit          m_pop;
  logic [7:0]  c_prio, c_chain;
  logic [15:0] c_time, c_flow, c_len;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_pkt = 0; m_cnt = 0; m_drop = 0; m_mism = 0; started = 1;
    end else begin
      m_sz  = exp_q.size();
      m_pop = (m_sz > 0) && m_desc_ready;
      if (m_pop) void'(exp_q.pop_front());
      if (s_axis_tvalid && s_axis_tready) begin
        m_n = $countones(s_axis_tkeep);
        if (!in_pkt) begin
          c_prio = s_desc_prio; c_chain = s_desc_chain; c_time = s_desc_time;
          c_flow = s_desc_flow_id; c_len = s_desc_pk_len; m_cnt = m_n;
        end else begin
          m_cnt = (m_cnt + m_n > 65535) ? 65535 : m_cnt + m_n;
        end
        if (s_axis_tlast) begin
          in_pkt = 0;
          if (m_cnt != int'(c_len) && m_mism < 65535) m_mism++;
          if (m_sz < DEPTH || m_pop) exp_q.push_back({c_prio, c_chain, c_time, c_flow, m_cnt[15:0]});
          else if (m_drop < 65535) m_drop++;
        end else begin
          in_pkt = 1;
        end
      end
    end
  end

  logic [63:0] hd;
  always @(negedge clk) begin
    if (started) begin
      check("valid", longint'(m_desc_valid), longint'(exp_q.size() != 0));
      check("level", longint'(fifo_level), longint'(exp_q.size()));
      check("drop_count", longint'(drop_count), longint'(m_drop));
      check("mismatch_count", longint'(mismatch_count), longint'(m_mism));
      hd = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
      check("head_prio", longint'(m_desc_prio), longint'(hd[63:56]));
      check("head_chain", longint'(m_desc_chain), longint'(hd[55:48]));
      check("head_time", longint'(m_desc_time), longint'(hd[47:32]));
      check("head_flow", longint'(m_desc_flow_id), longint'(hd[31:16]));
      check("head_len", longint'(m_desc_pk_len), longint'(hd[15:0]));
    end
  end

  task automatic drive(input logic v, input logic r, input logic l, input logic [KW-1:0] k,
                       input logic [7:0] prio, input logic [15:0] flow, input logic [15:0] plen);
    s_axis_tvalid = v; s_axis_tready = r; s_axis_tlast = l; s_axis_tkeep = k;
    s_desc_prio = prio; s_desc_chain = prio + 8'd1; s_desc_time = flow + 16'd100;
    s_desc_flow_id = flow; s_desc_pk_len = plen;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, '0, 8'h00, 16'h0, 16'h0);
  endtask

  localparam logic [KW-1:0] K_FULL = '1;
  localparam logic [KW-1:0] K_HALF = 32'h0000_FFFF;

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", longint'(fifo_level), 0);
    check("reset_valid", longint'(m_desc_valid), 0);
    rst = 0;

    // 2-beat full packet, parser length 64; second-beat parser fields must be ignored
    drive(1, 1, 0, K_FULL, 8'd5, 16'd3, 16'd64);
    drive(1, 1, 1, K_FULL, 8'd9, 16'd77, 16'd999);
    check("t1_valid", longint'(m_desc_valid), 1);
    check("t1_len", longint'(m_desc_pk_len), 64);
    check("t1_flow", longint'(m_desc_flow_id), 3);
    check("t1_prio", longint'(m_desc_prio), 5);
    check("t1_mism", longint'(mismatch_count), 0);
    m_desc_ready = 1; idle(1); m_desc_ready = 0;

    // 3-beat packet, 32+32+16 bytes, with stalled (tready=0) beats mixed in
    drive(1, 1, 0, K_FULL, 8'd2, 16'd11, 16'd100);
    drive(1, 0, 1, K_FULL, 8'd7, 16'd55, 16'd1);
    drive(1, 1, 0, K_FULL, 8'd7, 16'd55, 16'd1);
    drive(1, 0, 0, K_HALF, 8'd7, 16'd55, 16'd1);
    drive(1, 1, 1, K_HALF, 8'd7, 16'd55, 16'd1);
    check("t2_len", longint'(m_desc_pk_len), 80);
    check("t2_flow", longint'(m_desc_flow_id), 11);
    check("t2_mism", longint'(mismatch_count), 1);
    m_desc_ready = 1; idle(1); m_desc_ready = 0;
    idle(1);

    // 9 back-to-back single-beat packets into a blocked 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      logic [KW-1:0] k;
      k = (KW'(1) << (i + 1)) - KW'(1);
      drive(1, 1, 1, k, 8'(i), 16'(i + 1), 16'(i + 1));
    end
    idle(1);
    check("t3_level", longint'(fifo_level), 8);
    check("t3_drop", longint'(drop_count), 1);
    check("t3_head_flow", longint'(m_desc_flow_id), 1);
    check("t3_head_len", longint'(m_desc_pk_len), 1);

    // full FIFO: push and pop in the same cycle
    m_desc_ready = 1;
    drive(1, 1, 1, 32'h0000_00FF, 8'd40, 16'd100, 16'd8);
    m_desc_ready = 0;
    check("t4_level", longint'(fifo_level), 8);
    check("t4_drop", longint'(drop_count), 1);
    check("t4_head_flow", longint'(m_desc_flow_id), 2);
    m_desc_ready = 1;
    idle(7);
    check("t4_tail_flow", longint'(m_desc_flow_id), 100);
    check("t4_tail_len", longint'(m_desc_pk_len), 8);
    idle(3);
    m_desc_ready = 0;

    // reset after first beat of a 3-beat packet, then a fresh 1-beat packet
    drive(1, 1, 0, K_FULL, 8'd6, 16'd66, 16'd96);
    rst = 1;
    idle(1);
    rst = 0;
    drive(1, 1, 1, 32'h0000_000F, 8'd3, 16'd7, 16'd4);
    idle(1);
    check("t5_level", longint'(fifo_level), 1);
    check("t5_flow", longint'(m_desc_flow_id), 7);
    check("t5_len", longint'(m_desc_pk_len), 4);
    check("t5_drop", longint'(drop_count), 0);
    check("t5_mism", longint'(mismatch_count), 0);
    m_desc_ready = 1; idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/panic_desc_gen.md
# panic_desc_gen

Downstream stage of the header parser: taps the same RX AXI stream, latches the parser's combinational descriptor fields on the first beat of each packet, and counts the packet's actual byte length. At end of packet it commits one complete descriptor into a small FIFO and presents it to the scheduler with a valid/ready handshake. Overflow and length-mismatch events are counted for debug.

## Interface
- DATA_WIDTH, 256, tapped stream data width in bits (data itself not used)
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- FIFO_DEPTH, 8, descriptor FIFO entries; power of two, ≥2
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- s_axis_tkeep  in  KEEP_WIDTH  tapped byte enables
- s_axis_tvalid  in  1  tapped valid
- s_axis_tready  in  1  tapped ready (observed, not driven)
- s_axis_tlast  in  1  tapped last
- s_desc_prio  in  `PANIC_DESC_PRIO_SIZE  parser priority, valid on first beat
- s_desc_chain  in  `PANIC_DESC_CHAIN_SIZE  parser chain
- s_desc_time  in  `PANIC_DESC_TIME_SIZE  parser service time
- s_desc_pk_len  in  `PANIC_DESC_LEN_SIZE  parser length (IP len + 14)
- s_desc_flow_id  in  `PANIC_DESC_FLOW_SIZE  parser flow id
- m_desc_prio / m_desc_chain / m_desc_time / m_desc_flow_id  out  macro widths  head-of-FIFO fields
- m_desc_pk_len  out  `PANIC_DESC_LEN_SIZE  counted byte length of packet
- m_desc_valid  out  1  FIFO non-empty
- m_desc_ready  in  1  consumer accepts head
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- drop_count  out  16  descriptors dropped on full FIFO, saturating
- mismatch_count  out  16  packets where counted length ≠ parser length, saturating

## Operation
- beat = s_axis_tvalid && s_axis_tready; nothing happens on non-beat cycles.
- FSM: SOP (expect first beat) and MID (inside packet).
- SOP + beat: latch prio/chain/time/flow_id/pk_len into capture regs; byte_cnt ← popcount(tkeep). tlast=1 → commit this cycle, stay SOP; else → MID.
- MID + beat: byte_cnt += popcount(tkeep), saturating at all-ones of LEN_SIZE. tlast=1 → commit, → SOP.
- Commit entry = {captured prio, chain, time, flow_id, final byte_cnt}; compare final byte_cnt with captured pk_len; unequal → mismatch_count+1 (saturate 0xFFFF).
- Push permitted if FIFO not full, or full with pop in the same cycle. Otherwise the entry is discarded and drop_count+1 (saturate 0xFFFF). FSM still returns to SOP.
- Pop = m_desc_valid && m_desc_ready. Head fields are stable while m_desc_valid=1 and not popped.
- Read/write pointers are $clog2(FIFO_DEPTH)+1 bits with natural wrap; full/empty are derived from MSB comparison.
- Capture regs and byte_cnt are reused: values of a dropped or committed packet are overwritten by the next SOP.

## Timing
- Reset: FSM=SOP, FIFO empty, m_desc_valid=0, all m_desc_* fields 0, fifo_level=0, drop_count=0, mismatch_count=0, byte_cnt=0.
- Reset mid-packet: partial packet discarded; the next beat after reset release is treated as SOP.
- Commit latency: descriptor is visible at outputs (m_desc_valid=1 if FIFO was empty) the cycle after the tlast beat. FIFO is first-word-fall-through.
- Simultaneous push and pop: level unchanged, both take effect. Pop on empty is ignored.
- Back-to-back single-beat packets: one commit per cycle is sustained.
- Counters update the cycle after the triggering event.

## Test plan
- DATA_WIDTH=256, 2-beat packet, full tkeep both beats, parser pk_len=64, flow_id=3 → one descriptor, pk_len=64, flow_id=3, valid 1 cycle after tlast; mismatch_count=0.
- 3-beat packet, last tkeep=0x0000_FFFF, parser pk_len=100 → pk_len=80, mismatch_count=1.
- m_desc_ready=0, push 9 single-beat packets with FIFO_DEPTH=8 → fifo_level=8, drop_count=1; drain yields entries 1–8 in order.
- FIFO full, push and pop in the same cycle → no drop, fifo_level remains 8, new entry appears last.
- Assert rst after beat 1 of a 3-beat packet, then send a 1-beat packet with tlast → exactly one descriptor, carrying the new packet's fields; counters 0.
- Beats with tvalid=1 and tready=0 interleaved → ignored; byte count and FSM are unaffected.
